// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared instruction, state and access-size types for the memory-access stage
package mem_access_pkg;
  typedef struct packed {
    logic add;
    logic sub;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

  function automatic logic is_mem_op(input instructions i);
    return i.lb | i.lh | i.lw | i.lbu | i.lhu | i.sb | i.sh | i.sw;
  endfunction

  function automatic logic is_store_op(input instructions i);
    return i.sb | i.sh | i.sw;
  endfunction

  function automatic mem_size_t mem_size(input instructions i);
    return (i.lw | i.sw) ? WORD : (i.lh | i.lhu | i.sh) ? HALF : BYTE;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
import mem_access_pkg::*;

module mem_lane_align (
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic        is_signed,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);
  logic [1:0]  sh_off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // halfwords honour off[1] only and words are always lane 0
  always_comb begin
    sh_off   = size == WORD ? 2'b00 : size == HALF ? {off[1], 1'b0} : off;
    wstrb    = (size == WORD ? 4'b1111 : size == HALF ? 4'b0011 : 4'b0001) << sh_off;
    wdata    = size == WORD ? rs2 : size == HALF ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
    byte_v   = rdata[{off, 3'b000} +: 8];
    half_v   = off[1] ? rdata[31:16] : rdata[15:0];
    load_val = size == WORD ? rdata :
               size == HALF ? {{16{is_signed & half_v[15]}}, half_v} :
                              {{24{is_signed & byte_v[7]}}, byte_v};
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage with one request/ready transaction, timeout abort; MEM_MISALIGN_TRAP_EN enables misalignment traps
import mem_access_pkg::*;

module mem_access #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  instructions       instr,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              completed,
  output logic [31:0]       result,
  output logic              exc_misaligned,
  output logic              exc_bus
);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;

  mem_state_t        state_q, state_d;
  instructions       instr_q, instr_d;
  logic [31:0]       alu_q, alu_d, rs2_q, rs2_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_q, bus_d, mis_q, mis_d;
  logic              is_store, misaligned;
  logic [3:0]        wstrb;
  logic [31:0]       load_val;

  assign is_store = is_store_op(instr_q);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (mem_size(instr) == HALF && alu_result[0]) ||
                      (mem_size(instr) == WORD && alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_align (
    .size      (mem_size(instr_q)),
    .off       (alu_q[1:0]),
    .is_signed (instr_q.lb | instr_q.lh),
    .rs2       (rs2_q),
    .rdata     (mem_rdata),
    .wstrb     (wstrb),
    .wdata     (mem_wdata),
    .load_val  (load_val)
  );

  assign mem_req        = state_q == REQ;
  assign mem_we         = is_store;
  assign mem_addr       = {alu_q[ADDR_W-1:2], 2'b00};
  assign mem_wstrb      = is_store ? wstrb : 4'b0000;
  assign completed      = state_q == DONE;
  assign result         = result_q;
  assign exc_misaligned = mis_q;
  assign exc_bus        = bus_q;

  // next-state: capture on start, run the bus transaction, one-cycle DONE
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_d    = alu_q;
    rs2_d    = rs2_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    bus_d    = bus_q;
    mis_d    = mis_q;
    unique case (state_q)
      IDLE: if (enabled) begin
        instr_d = instr;
        alu_d   = alu_result;
        rs2_d   = rs2;
        cnt_d   = '0;
        bus_d   = 1'b0;
        mis_d   = misaligned;
        if (!is_mem_op(instr) || misaligned) begin
          state_d  = DONE;
          result_d = alu_result;
        end else
          state_d = REQ;
      end
      REQ: if (mem_ready) begin
        state_d  = DONE;
        result_d = is_store ? 32'd0 : load_val;
      end else if (TIMEOUT_CYC != 0 && cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC)) begin
        state_d  = DONE;
        bus_d    = 1'b1;
        result_d = 32'd0;
      end else
        cnt_d = cnt_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  // state and captured operands; async reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      alu_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      bus_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_q    <= alu_d;
      rs2_q    <= rs2_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      mis_q    <= mis_d;
    end
endmodule
